run_ctrl: RTL

Synthesizable run controller at the top of the MIPS pipelined CPU, between the board/bench reset source and the `mips` core. It turns the external asynchronous reset into the core's synchronous active-high reset pulse of fixed length, then lets the core run. It watches the fetch PC for end-of-program (`PC + 4 >= END_ADDR`), stops the core, and reports cycle count, completion or watchdog timeout.

---
 rtl/run_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
//
// Run controller sitting between the board/bench reset source and the MIPS
// core. After the external asynchronous reset is released it holds the core in
// synchronous reset for a fixed number of edges, then enables the core and
// counts run cycles. The run ends when the fetch PC reaches the end of the
// program (done) or when a watchdog limit is hit (timeout). Both terminal
// states are held until the next external reset.
//
// Parameters
//   END_ADDR    first address past the program; PC + 4 >= END_ADDR ends the run
//   RST_CYCLES  rising edges core_reset is held high after reset release (>= 1)
//   TIMEOUT     watchdog limit in RUN cycles (>= 2)
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-low
//   pc          in   32  IF-stage PC from the core
//   pc_valid    in   1   pc is meaningful this cycle
//   core_reset  out  1   synchronous active-high reset into the core
//   core_en     out  1   core clock enable, high only while running
//   done        out  1   sticky, program reached END_ADDR
//   timeout     out  1   sticky, watchdog expired
//   cycle_cnt   out  32  number of RUN edges elapsed
// -----------------------------------------------------------------------------
module run_ctrl #(
  parameter logic [31:0] END_ADDR   = 32'h0000_5000,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        core_reset,
  output logic        core_en,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_cnt
);

  localparam int unsigned HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [31:0]   TMO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TMO
  } state_t;

  state_t      r_state;
  logic [HW-1:0] r_hold_cnt;
  logic        r_core_reset;
  logic        r_core_en;
  logic        r_done;
  logic        r_timeout;
  logic [31:0] r_cycle_cnt;

  logic [32:0] w_pc_next;
  logic        w_end;

  // 33-bit sum so a PC near the top of the address space cannot wrap below
  // END_ADDR and be missed.
  assign w_pc_next = {1'b0, pc} + 33'd4;
  assign w_end     = pc_valid && (w_pc_next >= {1'b0, END_ADDR});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_HOLD;
      r_hold_cnt   <= '0;
      r_core_reset <= 1'b1;
      r_core_en    <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycle_cnt  <= '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          r_hold_cnt <= r_hold_cnt + HOLD_ONE;
          // Leaving on the RST_CYCLES-th edge makes the core sample exactly
          // RST_CYCLES reset edges.
          if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= S_RUN;
            r_core_reset <= 1'b0;
            r_core_en    <= 1'b1;
          end
        end
        S_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + 32'd1;
          // End of program has priority over the watchdog on the same edge.
          if (w_end) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_core_en <= 1'b0;
          end else if (r_cycle_cnt == TMO_LAST) begin
            r_state   <= S_TMO;
            r_timeout <= 1'b1;
            r_core_en <= 1'b0;
          end
        end
        default: begin
          // DONE and TMO are terminal until the external reset.
        end
      endcase
    end
  end

  assign core_reset = r_core_reset;
  assign core_en    = r_core_en;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign cycle_cnt  = r_cycle_cnt;

endmodule
